// File: rtl/gate_chk_pkg.sv
// Shared types and constants for the gate vector checker.
package gate_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] TT_OR2   = 4'b1110;
    localparam logic [3:0] TT_AND2  = 4'b1000;
    localparam logic [3:0] TT_XOR2  = 4'b0110;
    localparam logic [3:0] TT_NOR2  = 4'b0001;
    localparam logic [3:0] TT_NAND2 = 4'b0111;

    // Error counter must hold the full vector count 2^n_in.
    function automatic int unsigned res_width(input int unsigned n_in);
        return n_in + 1;
    endfunction

endpackage

// File: rtl/gate_chk_settle_ctr.sv
// Loadable settle counter; tc_c is high on the last settle cycle of a vector.
module gate_chk_settle_ctr #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic tc_c
);

    localparam int unsigned CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Counter parks at terminal count until reloaded for the next vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (en && !tc_c) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tc_c = (cnt == LAST);

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps all input vectors of a small gate, samples its output after a
// settle interval and compares against an expected truth table.
module gate_vector_checker
    import gate_chk_pkg::*;
#(
    parameter int unsigned          N_IN          = 2,
    parameter int unsigned          SETTLE_CYCLES = 2,
    parameter logic [(1<<N_IN)-1:0] EXP_TT        = TT_OR2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    output logic [N_IN-1:0]               dut_in,
    input  logic                          dut_out,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [res_width(N_IN)-1:0]    err_count,
    output logic [N_IN-1:0]               first_fail_vec,
    output logic                          chk_valid,
    output logic [N_IN-1:0]               chk_vec,
    output logic                          chk_ok
);

    localparam int unsigned NVEC = 1 << N_IN;
    localparam int unsigned RW   = res_width(N_IN);

    state_t        state, state_next;
    logic          start_sweep_c;
    logic          do_sample_c;
    logic          step_vec_c;
    logic          last_vec_c;
    logic          ok_c;
    logic          tc_c;
    logic [RW-1:0] err_upd_c;

    gate_chk_settle_ctr #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (start_sweep_c | step_vec_c),
        .en   (state == ST_SETTLE),
        .tc_c (tc_c)
    );

    // Case equality so an unknown DUT output is always a mismatch.
    assign ok_c       = (dut_out === EXP_TT[dut_in]);
    assign last_vec_c = (dut_in == N_IN'(NVEC - 1));

    always_comb begin
        err_upd_c = err_count;
        if (!ok_c && (err_count != RW'(NVEC))) begin
            err_upd_c = err_count + RW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        start_sweep_c = 1'b0;
        do_sample_c   = 1'b0;
        step_vec_c    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next    = ST_SETTLE;
                    start_sweep_c = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (tc_c) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                do_sample_c = 1'b1;
                if (last_vec_c) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_SETTLE;
                    step_vec_c = 1'b1;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_next    = ST_SETTLE;
                    start_sweep_c = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Vector register doubles as the DUT drive; results update on sample edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_in         <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_count      <= '0;
            first_fail_vec <= '0;
            chk_valid      <= 1'b0;
            chk_vec        <= '0;
            chk_ok         <= 1'b0;
        end else begin
            busy      <= (state_next == ST_SETTLE) || (state_next == ST_SAMPLE);
            done      <= (state_next == ST_DONE);
            chk_valid <= do_sample_c;
            if (do_sample_c) begin
                chk_vec <= dut_in;
                chk_ok  <= ok_c;
            end
            if (start_sweep_c) begin
                dut_in         <= '0;
                pass           <= 1'b0;
                err_count      <= '0;
                first_fail_vec <= '0;
            end else if (do_sample_c) begin
                err_count <= err_upd_c;
                if (!ok_c && (err_count == '0)) begin
                    first_fail_vec <= dut_in;
                end
                if (step_vec_c) begin
                    dut_in <= dut_in + N_IN'(1);
                end
                if (last_vec_c) begin
                    pass <= (err_upd_c == '0);
                end
            end
        end
    end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: 2-input sweeps against several gate models plus a 3-input OR sweep.
module tb_gate_vector_checker;
    import gate_chk_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [1:0] mode;
    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass, chk_valid, chk_ok;
    logic [2:0] err_count;
    logic [1:0] first_fail_vec, chk_vec;

    logic       start3;
    logic [2:0] dut_in3;
    logic       dut_out3;
    logic       busy3, done3, pass3, chk_valid3, chk_ok3;
    logic [3:0] err_count3;
    logic [2:0] first_fail_vec3, chk_vec3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Gate model under test: 0 OR, 1 AND, 2 tied low, 3 tied high.
    always_comb begin
        case (mode)
            2'd0:    dut_out = |dut_in;
            2'd1:    dut_out = &dut_in;
            2'd2:    dut_out = 1'b0;
            default: dut_out = 1'b1;
        endcase
    end
    assign dut_out3 = |dut_in3;

    gate_vector_checker #(
        .N_IN(2), .SETTLE_CYCLES(2), .EXP_TT(TT_OR2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .first_fail_vec(first_fail_vec), .chk_valid(chk_valid), .chk_vec(chk_vec),
        .chk_ok(chk_ok)
    );

    gate_vector_checker #(
        .N_IN(3), .SETTLE_CYCLES(1), .EXP_TT(8'b1111_1110)
    ) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .dut_in(dut_in3), .dut_out(dut_out3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
        .first_fail_vec(first_fail_vec3), .chk_valid(chk_valid3), .chk_vec(chk_vec3),
        .chk_ok(chk_ok3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One 2-input sweep; returns at the DONE cycle (chain) or the following idle cycle.
    task automatic sweep(input string tag, input logic [1:0] m, input int exp_err,
                         input int exp_ff, input logic exp_pass, input logic [3:0] exp_pat,
                         input bit poke, input bit skip_start, input bit chain);
        int         cycles = 0;
        int         nvalid = 0;
        int         bad    = 0;
        logic [3:0] pat    = '0;
        mode = m;
        if (!skip_start) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_clr"}, {28'd0, pass, err_count}, 32'd0);
        for (int i = 0; i < 100; i++) begin
            if (chk_valid) begin
                if (chk_vec !== 2'(nvalid)) bad++;
                if (nvalid < 4) pat[2'(nvalid)] = chk_ok;
                nvalid++;
            end
            if (!busy) break;
            if (dut_in !== 2'(cycles / 3)) bad++;
            start = poke && (cycles == 3 || cycles == 6);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        check({tag, "_busy_cycles"}, cycles, 32'd12);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_pass"}, pass, exp_pass);
        check({tag, "_err"}, err_count, exp_err);
        check({tag, "_ff"}, first_fail_vec, exp_ff);
        check({tag, "_chk_ok_seq"}, pat, exp_pat);
        check({tag, "_samples"}, nvalid, 32'd4);
        check({tag, "_seq_errs"}, bad, 32'd0);
        check({tag, "_hold_last"}, dut_in, 2'd3);
        if (chain) begin
            start = 1'b1;
        end else begin
            @(negedge clk);
            check({tag, "_idle"}, {done, busy}, 2'b00);
            check({tag, "_stable"}, {pass, err_count, first_fail_vec},
                  {exp_pass, 3'(exp_err), 2'(exp_ff)});
        end
    endtask

    initial begin
        int c3;
        int v3;
        int o3;
        rst_n  = 1'b0;
        start  = 1'b0;
        start3 = 1'b0;
        mode   = 2'd0;
        repeat (2) @(negedge clk);
        check("rst_outs", {dut_in, busy, done, pass, err_count, first_fail_vec}, 32'd0);
        check("rst_chk", {chk_valid, chk_vec, chk_ok}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep("or2",   2'd0, 0, 0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
        sweep("and2",  2'd1, 2, 1, 1'b0, 4'b1001, 1'b0, 1'b0, 1'b0);
        sweep("tie0",  2'd2, 3, 1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0);
        sweep("tie1",  2'd3, 1, 0, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0);
        sweep("poke",  2'd1, 2, 1, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b1);
        sweep("chain", 2'd0, 0, 0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b0);

        // Abort a tied-low sweep while vector 2 is settling.
        mode  = 2'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (dut_in == 2'd2) break;
            @(negedge clk);
        end
        check("pre_rst_state", {busy, dut_in, err_count}, {1'b1, 2'd2, 3'd1});
        rst_n = 1'b0;
        #1;
        check("async_rst_outs", {dut_in, busy, done, pass, err_count, first_fail_vec}, 32'd0);
        check("async_rst_chk", {chk_valid, chk_vec, chk_ok}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sweep("post_rst", 2'd0, 0, 0, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);

        // 3-input OR with single-cycle settle.
        c3 = 0; v3 = 0; o3 = 0;
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (chk_valid3) begin
                v3++;
                if (chk_ok3) o3++;
            end
            if (!busy3) break;
            c3++;
            @(negedge clk);
        end
        check("n3_busy_cycles", c3, 32'd16);
        check("n3_samples", v3, 32'd8);
        check("n3_ok_count", o3, 32'd8);
        check("n3_result", {done3, pass3, err_count3}, {1'b1, 1'b1, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Synthesizable stimulus-and-check engine for small combinational gate blocks.
- Drives every input vector into a gate DUT, waits a settle interval, samples the DUT output and compares it with a parameterised expected truth table.
- Reports pass/fail, an error count and the first failing vector.
- Used as the on-chip counterpart to the gate primitives, for bring-up and regression without a simulator-only testbench.

Parameters:
- N_IN, 2: number of DUT inputs, 1..4. Sweep covers 2^N_IN vectors.
- SETTLE_CYCLES, 2: cycles dut_in is held before dut_out is sampled. Must be >= 1.
- EXP_TT, 4'b1110: expected truth table, width 2^N_IN. Bit k is the expected output for input vector k. The default is the 2-input OR.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  sweep request, sampled only in IDLE or DONE
- dut_in  out  N_IN  vector driven to the DUT inputs
- dut_out  in  1  DUT output under test
- busy  out  1  high while a sweep is in progress
- done  out  1  one-cycle pulse at sweep end
- pass  out  1  result of the last completed sweep (1 = no mismatches)
- err_count  out  N_IN+1  number of mismatching vectors in the current or last sweep
- first_fail_vec  out  N_IN  lowest vector that mismatched; 0 if none
- chk_valid  out  1  one-cycle pulse on each sample, for logging
- chk_vec  out  N_IN  vector sampled when chk_valid is high
- chk_ok  out  1  compare result when chk_valid is high

Behaviour:
- Reset (async assert, sync release): state IDLE; dut_in=0; busy=0, done=0, pass=0, err_count=0, first_fail_vec=0, chk_valid=0, chk_vec=0, chk_ok=0.
- Reset mid-sweep aborts immediately to these values. No partial results are retained.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE:
  - start=1 -> SETTLE, with vec=0, settle_cnt=0.
  - err_count, first_fail_vec and pass are cleared on that same edge.
  - busy=1 from the next cycle.
- SETTLE:
  - dut_in=vec.
  - settle_cnt increments each cycle.
  - When settle_cnt==SETTLE_CYCLES-1 -> SAMPLE.
  - SETTLE lasts exactly SETTLE_CYCLES cycles per vector.
- SAMPLE:
  - dut_out is compared with EXP_TT[vec]. Any non-0/1 value in simulation counts as a mismatch.
  - chk_valid=1, chk_vec=vec and chk_ok=compare are registered, so they are visible in the following cycle.
  - On mismatch: err_count increments (saturating at 2^N_IN). If this is the first error of the sweep, first_fail_vec=vec.
  - If vec==2^N_IN-1 -> DONE. Otherwise vec+1 -> SETTLE with settle_cnt=0.
  - vec never wraps inside a sweep.
- DONE (one cycle):
  - done=1, busy=0.
  - pass=(err_count==0), computed including the final sample's result.
  - dut_in holds the last vector.
  - start=1 here begins a new sweep (-> SETTLE, counters cleared). Otherwise -> IDLE.
- start while busy is ignored. No queuing.
- Timing: busy stays high for exactly 2^N_IN*(SETTLE_CYCLES+1) cycles. done is high in the cycle after busy falls.
- pass, err_count and first_fail_vec are stable from DONE until the next accepted start.
- dut_in changes only on the SAMPLE->SETTLE transition and on sweep start. It is glitch-free at the register level.

Decomposition:
- Shared package gate_chk_pkg holds:
  - the state enum (IDLE/SETTLE/SAMPLE/DONE);
  - truth-table constants TT_OR2=4'b1110, TT_AND2=4'b1000, TT_XOR2=4'b0110, TT_NOR2=4'b0001, TT_NAND2=4'b0111;
  - a function computing the result width from N_IN.
- One natural sub-module, gate_chk_settle_ctr: loadable settle counter with a terminal-count output.
- The FSM, compare and result registers stay in the top.

Test Plan:
- OR2 DUT, defaults, start pulse:
  - dut_in steps 0,1,2,3 with each vector held 3 cycles;
  - busy high for 12 cycles, then done=1, pass=1, err_count=0, first_fail_vec=0;
  - chk_ok=1 on all four chk_valid pulses.
- AND2 DUT against EXP_TT=TT_OR2 -> err_count=2, first_fail_vec=1, pass=0; chk_ok sequence 1,0,0,1.
- dut_out tied 0 -> err_count=3, first_fail_vec=1. dut_out tied 1 -> err_count=1, first_fail_vec=0.
- start re-pulsed at vectors 1 and 2 of a sweep -> ignored; done still occurs exactly 12 cycles after busy rose. A start in the DONE cycle -> new sweep begins with no IDLE cycle, and err_count is cleared.
- rst_n asserted during SETTLE of vector 2 -> all outputs 0 asynchronously, dut_in=0. After release, a start gives a full clean sweep with correct results.
- N_IN=3, SETTLE_CYCLES=1, EXP_TT=8'b1111_1110, 3-input OR DUT -> busy 16 cycles, 8 samples, pass=1.
